bcd_keypad_entry: RTL

Input-side counterpart of the display path: collects up to three decimal digits and a sign from a keypad or pushbutton front end, then converts the signed BCD entry to an 8-bit two's-complement value. The conversion is sequential (reverse double-dabble). Live entry digits are exposed for the multiplexed 7-segment driver. The result is handed to the datapath through a valid/ready handshake, with range checking against the signed 8-bit range −128..+127.

---
 rtl/bcd_keypad_entry_if.sv | 10 +
 rtl/bcd_keypad_entry.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_keypad_entry_if.sv
// Result handshake between bcd_keypad_entry (master) and the datapath (slave).
interface bcd_keypad_entry_if;
  logic [7:0] value;
  logic       out_valid;
  logic       overflow;
  logic       out_ready;

  modport master (output value, output out_valid, output overflow, input out_ready);
  modport slave  (input value, input out_valid, input overflow, output out_ready);
endinterface

// File: rtl/bcd_keypad_entry.sv
// Signed 3-digit BCD keypad entry with sequential reverse double-dabble
// conversion to 8-bit two's complement and a valid/ready result handshake.
// Optional macro BCD_ENTRY_SAT_EN: saturate the value on overflow instead of
// returning 8'h00.
module bcd_keypad_entry (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       digit_valid,
  input  logic [3:0]                 digit,
  input  logic                       sign_toggle,
  input  logic                       clear,
  input  logic                       enter,
  bcd_keypad_entry_if.master         res_if,
  output logic                       busy,
  output logic [3:0]                 disp_hun,
  output logic [3:0]                 disp_tens,
  output logic [3:0]                 disp_ones,
  output logic                       disp_neg
);

  localparam int unsigned DIG_W   = 4;
  localparam int unsigned BCD_W   = 3 * DIG_W;
  localparam int unsigned BIN_W   = 10;
  localparam int unsigned OUT_W   = 8;
  localparam int unsigned SH_W    = BCD_W + BIN_W;
  localparam int unsigned ITER_W  = 4;
  localparam int unsigned ITERS   = 10;
  localparam int unsigned CNT_W   = 2;

  typedef enum logic [1:0] {ST_ENTRY, ST_CONVERT, ST_CHECK, ST_DONE} state_e;

  state_e              state_q, state_d;
  logic [DIG_W-1:0]    hun_q, hun_d, tens_q, tens_d, ones_q, ones_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [OUT_W-1:0]    value_q, value_d;
  logic                ovf_q, ovf_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;

  logic [SH_W-1:0]     shift_v;
  logic [BCD_W-1:0]    bcd_adj;
  logic [OUT_W-1:0]    neg_mag;
  logic                ovf_v;
  logic [OUT_W-1:0]    val_v;

  // Reverse double-dabble correction for one BCD nibble.
  function automatic logic [DIG_W-1:0] adj3(input logic [DIG_W-1:0] n);
    return (n >= DIG_W'(8)) ? n - DIG_W'(3) : n;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_ENTRY;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ENTRY:   if (!clear && enter) state_d = ST_CONVERT;
      ST_CONVERT: if (iter_q == ITER_W'(ITERS - 1)) state_d = ST_CHECK;
      ST_CHECK:   state_d = ST_DONE;
      ST_DONE:    if (out_valid_q && res_if.out_ready) state_d = ST_ENTRY;
      default:    state_d = ST_ENTRY;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    hun_d       = hun_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    bcd_d       = bcd_q;
    bin_d       = bin_q;
    iter_d      = iter_q;
    value_d     = value_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    busy_d      = (state_q != ST_ENTRY);

    shift_v = {bcd_q, bin_q} >> 1;
    bcd_adj = '0;
    for (int i = 0; i < 3; i++) begin
      bcd_adj[DIG_W*i +: DIG_W] = adj3(shift_v[BIN_W + DIG_W*i +: DIG_W]);
    end

    neg_mag = ~bin_q[OUT_W-1:0] + OUT_W'(1);
    ovf_v   = neg_q ? (bin_q > BIN_W'(128)) : (bin_q > BIN_W'(127));
`ifdef BCD_ENTRY_SAT_EN
    if (ovf_v)      val_v = neg_q ? OUT_W'(8'h80) : OUT_W'(8'h7F);
`else
    if (ovf_v)      val_v = '0;
`endif
    else if (neg_q) val_v = neg_mag;
    else            val_v = bin_q[OUT_W-1:0];

    case (state_q)
      ST_ENTRY: begin
        if (clear) begin
          hun_d  = '0;
          tens_d = '0;
          ones_d = '0;
          cnt_d  = '0;
          neg_d  = 1'b0;
        end else if (enter) begin
          bcd_d  = {hun_q, tens_q, ones_q};
          bin_d  = '0;
          iter_d = '0;
        end else if (sign_toggle) begin
          neg_d = ~neg_q;
        end else if (digit_valid && (cnt_q != CNT_W'(3)) && (digit <= DIG_W'(9))) begin
          hun_d  = tens_q;
          tens_d = ones_q;
          ones_d = digit;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      ST_CONVERT: begin
        bcd_d  = bcd_adj;
        bin_d  = shift_v[BIN_W-1:0];
        iter_d = (iter_q == ITER_W'(ITERS - 1)) ? '0 : iter_q + ITER_W'(1);
      end
      ST_CHECK: begin
        value_d = val_v;
        ovf_d   = ovf_v;
      end
      ST_DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (res_if.out_ready) begin
          out_valid_d = 1'b0;
          hun_d       = '0;
          tens_d      = '0;
          ones_d      = '0;
          cnt_d       = '0;
          neg_d       = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hun_q       <= '0;
      tens_q      <= '0;
      ones_q      <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      bcd_q       <= '0;
      bin_q       <= '0;
      iter_q      <= '0;
      value_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      hun_q       <= hun_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      bcd_q       <= bcd_d;
      bin_q       <= bin_d;
      iter_q      <= iter_d;
      value_q     <= value_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // All BCD digits must have been shifted out once conversion completes.
  a_bcd_drained: assert property (@(posedge clk) disable iff (!reset)
                                  (state_q == ST_CHECK) |-> (bcd_q == '0));

  assign res_if.value     = value_q;
  assign res_if.out_valid = out_valid_q;
  assign res_if.overflow  = ovf_q;
  assign busy             = busy_q;
  assign disp_hun         = hun_q;
  assign disp_tens        = tens_q;
  assign disp_ones        = ones_q;
  assign disp_neg         = neg_q;

endmodule
